// File: rtl/song_reader.sv
// ----------------------------------------------------------------------------
// song_reader
//   Sequencer that sits directly upstream of note_player. It walks the song
//   ROM one entry at a time. For each entry it presents the (note, duration)
//   pair with a one-cycle load strobe. It then waits for note_player to
//   report done before moving to the next entry. It flags end of song when it
//   reads an end marker (duration 0) or finishes the last entry.
//
// Ports
//   clk              : system clock
//   reset            : synchronous, active-high reset
//   play             : 1 = advance through the song, 0 = pause
//   song             : song select
//   rom_addr         : song ROM address, {latched song, note index}
//   rom_data         : ROM word, [11:6] note, [5:0] duration; the ROM is
//                      registered, so the word is valid one cycle after
//                      rom_addr
//   note_done        : done_with_note level from note_player
//   note_to_load     : note handed to note_player (registered)
//   duration_to_load : duration in beats handed to note_player (registered)
//   load_new_note    : one-cycle strobe, note/duration valid
//   song_done        : level, high once the song has finished
// ----------------------------------------------------------------------------
module song_reader #(
    parameter int IDX_WIDTH  = 5,
    parameter int SONG_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            play,
    input  logic [SONG_WIDTH-1:0]           song,
    output logic [SONG_WIDTH+IDX_WIDTH-1:0] rom_addr,
    input  logic [11:0]                     rom_data,
    input  logic                            note_done,
    output logic [5:0]                      note_to_load,
    output logic [5:0]                      duration_to_load,
    output logic                            load_new_note,
    output logic                            song_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        LOAD,
        BLANK,
        WAIT_NOTE,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [SONG_WIDTH-1:0]  song_q, song_d;
    logic [5:0]             note_q, note_d;
    logic [5:0]             dur_q, dur_d;

    logic song_change;
    logic end_marker;
    logic last_idx;
    logic advance;

    // A change of song select overrides every state, so it is decoded once
    // and checked first in every next-state and datapath decision.
    assign song_change = (song != song_q);
    assign end_marker  = (rom_data[5:0] == 6'd0);
    assign last_idx    = (idx_q == '1);
    // note_done counts only while playing; a pause freezes WAIT_NOTE.
    assign advance     = note_done & play;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (song_change) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (play) begin
                        state_d = FETCH;
                    end
                end
                // Address is stable this cycle; the registered ROM
                // returns the word during WAIT_ROM.
                FETCH: begin
                    state_d = WAIT_ROM;
                end
                WAIT_ROM: begin
                    if (end_marker) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    state_d = BLANK;
                end
                // note_done is a level and may still be high from the
                // previous note, so one cycle passes before it is sampled.
                BLANK: begin
                    state_d = WAIT_NOTE;
                end
                WAIT_NOTE: begin
                    if (advance) begin
                        if (last_idx) begin
                            state_d = DONE;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath next values: song latch, index, note/duration registers
    // ------------------------------------------------------------------
    always_comb begin
        song_d = song_q;
        idx_d  = idx_q;
        note_d = note_q;
        dur_d  = dur_q;
        if (song_change) begin
            song_d = song;
            idx_d  = '0;
        end else begin
            case (state_q)
                WAIT_ROM: begin
                    // The end marker leaves the previous note/duration intact.
                    if (!end_marker) begin
                        note_d = rom_data[11:6];
                        dur_d  = rom_data[5:0];
                    end
                end
                WAIT_NOTE: begin
                    // The index never wraps; the last entry ends the song.
                    if (advance && !last_idx) begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            song_q <= '0;
            idx_q  <= '0;
            note_q <= '0;
            dur_q  <= '0;
        end else begin
            song_q <= song_d;
            idx_q  <= idx_d;
            note_q <= note_d;
            dur_q  <= dur_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The strobe and done flag decode the registered state. Reset or a song
    // change sends the state to IDLE, which clears both on the next cycle.
    always_comb begin
        load_new_note = (state_q == LOAD);
        song_done     = (state_q == DONE);
    end

    assign rom_addr         = {song_q, idx_q};
    assign note_to_load     = note_q;
    assign duration_to_load = dur_q;

endmodule

// File: tb/tb_song_reader.sv
// ----------------------------------------------------------------------------
// tb_song_reader
//   Directed bench for song_reader with a registered song ROM model. Each
//   expected load (address, note, duration) is queued before the stimulus
//   that causes it. A monitor pops the queue on every load strobe and
//   compares.
// ----------------------------------------------------------------------------
module tb_song_reader;

    localparam int IW = 5;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          play;
    logic          note_done;
    logic [SW-1:0] song;
    logic [SW+IW-1:0] rom_addr;
    logic [11:0]   rom_data;
    logic [5:0]    note_to_load;
    logic [5:0]    duration_to_load;
    logic          load_new_note;
    logic          song_done;

    logic [11:0]   rom [0:127];

    typedef struct packed {
        logic [6:0] addr;
        logic [5:0] note;
        logic [5:0] dur;
    } exp_t;

    exp_t sb[$];

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int c0;
    int l1;

    song_reader #(
        .IDX_WIDTH (IW),
        .SONG_WIDTH(SW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .play            (play),
        .song            (song),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .note_done       (note_done),
        .note_to_load    (note_to_load),
        .duration_to_load(duration_to_load),
        .load_new_note   (load_new_note),
        .song_done       (song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered ROM: word valid the cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [6:0] a, input logic [5:0] n, input logic [5:0] d);
        exp_t e;
        e.addr = a;
        e.note = n;
        e.dur  = d;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Poll on falling edges until the scoreboard drains to target entries.
    task automatic wait_sb(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (sb.size() > target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() > target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout, %0d loads outstanding, expected %0d", name, sb.size(), target);
        end
    endtask

    // Monitor: every load strobe must match the oldest expected load.
    always @(negedge clk) begin
        exp_t e;
        if (load_new_note === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_load: got load at addr %0d, expected none (cycle %0d)", rom_addr, cyc);
            end else begin
                e = sb.pop_front();
                check("load_addr", 32'(rom_addr), 32'(e.addr));
                check("load_note", 32'(note_to_load), 32'(e.note));
                check("load_dur", 32'(duration_to_load), 32'(e.dur));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = {6'd1, 6'd1};
        // Song 0: two notes then end marker.
        rom[0] = {6'd10, 6'd4};
        rom[1] = {6'd20, 6'd7};
        rom[2] = {6'd5, 6'd0};
        // Song 1: all 32 entries non-zero.
        for (int i = 0; i < 32; i++) rom[32 + i] = {6'(i + 1), 6'(i + 2)};
        // Song 2: one note then end marker with a non-zero note field.
        rom[64] = {6'd33, 6'd9};
        rom[65] = {6'd63, 6'd0};
        // Song 3: used for pause and mid-song change.
        for (int i = 0; i < 32; i++) rom[96 + i] = {6'(i * 3 + 1), 6'(i + 3)};

        reset     = 1'b1;
        play      = 1'b0;
        note_done = 1'b0;
        song      = '0;
        repeat (3) tick();
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_note", 32'(note_to_load), 0);
        check("rst_dur", 32'(duration_to_load), 0);
        check("rst_load", 32'(load_new_note), 0);
        check("rst_done", 32'(song_done), 0);

        // Song 0 with note_done held high across loads.
        reset = 1'b0;
        tick();
        push(7'd0, 6'd10, 6'd4);
        push(7'd1, 6'd20, 6'd7);
        note_done = 1'b1;
        play      = 1'b1;
        c0        = cyc;
        wait_sb(1, 20, "song0_first");
        check("first_load_latency", 32'(cyc), 32'(c0 + 3));
        l1 = cyc;
        wait_sb(0, 20, "song0_second");
        check("load_gap", 32'(cyc), 32'(l1 + 5));
        repeat (10) tick();
        check("s0_done", 32'(song_done), 1);
        check("s0_addr_hold", 32'(rom_addr), 2);
        check("s0_note_hold", 32'(note_to_load), 20);
        check("s0_dur_hold", 32'(duration_to_load), 7);
        for (int i = 0; i < 6; i++) begin
            play = ~play;
            tick();
            check("done_hold_play", 32'(song_done), 1);
        end
        play = 1'b1;

        // Song 1: full 32-entry song.
        for (int i = 0; i < 32; i++) push(7'(32 + i), 6'(i + 1), 6'(i + 2));
        song = 2'd1;
        tick();
        check("s1_addr_start", 32'(rom_addr), 32);
        check("s1_done_clear", 32'(song_done), 0);
        wait_sb(0, 400, "song1_all");
        repeat (6) tick();
        check("s1_done", 32'(song_done), 1);
        check("s1_addr_last", 32'(rom_addr), 63);

        // Song 3: pause in WAIT_NOTE while note_done is high.
        play      = 1'b0;
        note_done = 1'b0;
        song      = 2'd3;
        tick();
        check("s3_addr_start", 32'(rom_addr), 96);
        check("s3_done_clear", 32'(song_done), 0);
        for (int i = 0; i < 6; i++) push(7'(96 + i), 6'(i * 3 + 1), 6'(i + 3));
        play = 1'b1;
        wait_sb(5, 20, "s3_first");
        play      = 1'b0;
        note_done = 1'b1;
        repeat (10) tick();
        check("pause_addr", 32'(rom_addr), 96);
        check("pause_no_load", 32'(sb.size()), 5);
        play = 1'b1;
        c0   = cyc;
        tick();
        check("resume_addr", 32'(rom_addr), 97);
        wait_sb(4, 20, "s3_resume");
        check("resume_latency", 32'(cyc), 32'(c0 + 3));
        wait_sb(0, 100, "s3_rest");
        note_done = 1'b0;
        repeat (4) tick();
        check("s3_park_idx5", 32'(rom_addr), 101);

        // Mid-song change from song 3 (idx 5) to song 2.
        push(7'd64, 6'd33, 6'd9);
        song = 2'd2;
        tick();
        check("chg_addr", 32'(rom_addr), 64);
        check("chg_done", 32'(song_done), 0);
        wait_sb(0, 20, "s2_first");
        note_done = 1'b1;
        repeat (8) tick();
        check("s2_done", 32'(song_done), 1);
        check("s2_addr_hold", 32'(rom_addr), 65);
        check("s2_note_hold", 32'(note_to_load), 33);
        check("s2_dur_hold", 32'(duration_to_load), 9);

        // Reset asserted during LOAD.
        note_done = 1'b0;
        play      = 1'b1;
        song      = 2'd0;
        push(7'd0, 6'd10, 6'd4);
        wait_sb(0, 20, "s0_reload");
        check("in_load", 32'(load_new_note), 1);
        reset = 1'b1;
        play  = 1'b0;
        tick();
        check("midrst_addr", 32'(rom_addr), 0);
        check("midrst_note", 32'(note_to_load), 0);
        check("midrst_dur", 32'(duration_to_load), 0);
        check("midrst_load", 32'(load_new_note), 0);
        check("midrst_done", 32'(song_done), 0);
        reset = 1'b0;
        repeat (5) tick();
        check("sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
